// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle mult/multu/div/divu unit for the execute stage.
// Latency: start sampled at edge N, DATA_W RUN cycles, done pulse in cycle N+DATA_W+1.
// Backpressure: holds stall high from the start cycle until DONE; flush cancels in any state.
module muldiv_sequencer #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              flush,
  output logic              stall,
  output logic              done,
  output logic [1:0]        hilo_we,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t              state, state_nxt;
  logic [1:0]          op_q;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   opnd;     // multiplicand (mult) or divisor (div), magnitude
  logic [DATA_W:0]     hi_r;     // accumulator (mult) or partial remainder (div)
  logic [DATA_W-1:0]   lo_r;     // multiplier (mult) or dividend/quotient (div)
  logic [DATA_W-1:0]   a_raw;    // dividend as issued, returned on divide by zero
  logic                sign_a, sign_b;

  // Operand magnitudes at issue; signed ops take the absolute value, so the
  // most negative value becomes the unsigned magnitude 2^(DATA_W-1).
  logic                in_signed;
  logic [DATA_W-1:0]   abs_a, abs_b;

  // One engine iteration and the sign-corrected final result.
  logic                is_div, is_signed, last_iter, div_by_zero;
  logic [DATA_W:0]     mul_sum;
  logic [DATA_W:0]     rem_sh;
  logic [DATA_W:0]     rem_diff;
  logic [DATA_W-1:0]   quot_sh;
  logic [DATA_W:0]     step_hi;
  logic [DATA_W-1:0]   step_lo;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   quot, rem;
  logic [DATA_W-1:0]   res_hi, res_lo;

  // Operand conditioning for the issue cycle
  always_comb begin
    in_signed = ~op[0];
    abs_a     = (in_signed && src_a[DATA_W-1]) ? (~src_a + 1'b1) : src_a;
    abs_b     = (in_signed && src_b[DATA_W-1]) ? (~src_b + 1'b1) : src_b;
  end

  // Single shift-add / restoring-divide iteration plus result sign correction
  always_comb begin
    is_div      = op_q[1];
    is_signed   = ~op_q[0];
    last_iter   = (cnt == CNT_W'(DATA_W - 1));
    div_by_zero = is_div && (opnd == '0);

    mul_sum  = hi_r + (lo_r[0] ? {1'b0, opnd} : '0);
    rem_sh   = {hi_r[DATA_W-1:0], lo_r[DATA_W-1]};
    quot_sh  = {lo_r[DATA_W-2:0], 1'b0};
    rem_diff = rem_sh - {1'b0, opnd};

    if (is_div) begin
      if (rem_sh >= {1'b0, opnd}) begin
        step_hi = rem_diff;
        step_lo = quot_sh | {{(DATA_W-1){1'b0}}, 1'b1};
      end else begin
        step_hi = rem_sh;
        step_lo = quot_sh;
      end
    end else begin
      step_hi = {1'b0, mul_sum[DATA_W:1]};
      step_lo = {mul_sum[0], lo_r[DATA_W-1:1]};
    end

    prod = {step_hi[DATA_W-1:0], step_lo};
    if (is_signed && (sign_a ^ sign_b)) prod = ~prod + 1'b1;

    quot = step_lo;
    rem  = step_hi[DATA_W-1:0];
    if (is_signed && (sign_a ^ sign_b)) quot = ~quot + 1'b1;
    if (is_signed && sign_a)            rem  = ~rem + 1'b1;

    if (div_by_zero) begin
      res_hi = a_raw;
      res_lo = '1;
    end else if (is_div) begin
      res_hi = rem;
      res_lo = quot;
    end else begin
      res_hi = prod[2*DATA_W-1:DATA_W];
      res_lo = prod[DATA_W-1:0];
    end
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; flush wins in every state
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = RUN;
        RUN:     if (last_iter) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs decoded from state; stall in IDLE is combinational on start
  always_comb begin
    stall = 1'b0;
    done  = 1'b0;
    case (state)
      IDLE:    stall = start & ~flush;
      RUN:     stall = 1'b1;
      DONE:    done  = ~flush;
      default: ;
    endcase
    hilo_we = {2{done}};
  end

  // Datapath: operand latch, iteration registers and result registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q   <= '0;
      cnt    <= '0;
      opnd   <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
      a_raw  <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      hi_o   <= '0;
      lo_o   <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (state == IDLE && start) begin
      op_q   <= op;
      cnt    <= '0;
      opnd   <= op[1] ? abs_b : abs_a;
      lo_r   <= op[1] ? abs_a : abs_b;
      hi_r   <= '0;
      a_raw  <= src_a;
      sign_a <= src_a[DATA_W-1];
      sign_b <= src_b[DATA_W-1];
    end else if (state == RUN) begin
      hi_r <= step_hi;
      lo_r <= step_lo;
      cnt  <= cnt + 1'b1;
      if (last_iter) begin
        hi_o <= res_hi;
        lo_o <= res_lo;
      end
    end
  end

endmodule
